// File: rtl/intdiv_iter_pkg.sv
// Shared types for the iterative integer divider: operation and FSM state encodings.
// No logic; latency n/a.
// No handshake; consumed by intdiv_iter and its interface.
package intdiv_iter_pkg;

  // op[0]=1 marks the unsigned forms, op[1]=1 selects the remainder
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } intdiv_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    POST,
    DONE
  } intdiv_state_t;

  // Quotient bits per iteration must be a power of two that divides 32
  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

endpackage

// File: rtl/intdiv_iter_if.sv
// Request/result bundle between the execute stage and the divider.
// Wires only; latency n/a.
// Valid/ready on both the request and the result side.
interface intdiv_iter_if
  import intdiv_iter_pkg::*;
#(
  parameter int XLEN = 64
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  intdiv_op_t      op_i;
  logic            w_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;

  modport master (
    output in_valid_i, a_i, b_i, op_i, w_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, op_i, w_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/intdiv_iter_step.sv
// One restoring division step: shift {rem,quot} left, trial-subtract, keep if non-negative.
// Purely combinational.
// No handshake.
module intdiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);
  // The shifted partial remainder needs XLEN+1 bits; the kept remainder is always
  // below the divisor, so it fits back into XLEN bits.
  logic [XLEN:0] sh;
  logic          ge;

  assign sh     = {rem_i, quot_i[XLEN-1]};
  assign ge     = (sh >= {1'b0, dvs_i});
  assign rem_o  = ge ? (sh[XLEN-1:0] - dvs_i) : sh[XLEN-1:0];
  assign quot_o = {quot_i[XLEN-2:0], ge};
endmodule

// File: rtl/intdiv_iter.sv
// Iterative RISC-V divider (DIV/DIVU/REM/REMU + W forms), BPC quotient bits per cycle; INTDIV_EARLY_TERM_EN skips dividend leading zeros.
// Latency 2+N/BPC cycles from acceptance to out_valid_o (2 for divide by zero).
// Result held in DONE until out_ready_i; no new request accepted until back in IDLE; flush_i kills any op.
module intdiv_iter
  import intdiv_iter_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  intdiv_iter_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  if (!bpc_legal(BPC) || (XLEN != 32 && XLEN != 64)) begin : g_param_check
    $error("intdiv_iter: unsupported XLEN/BPC combination");
  end

  intdiv_state_t   state_q, state_d;
  intdiv_op_t      op_q;
  logic            w_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] rem_q, quot_q, dvs_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            q_neg_q, r_neg_q;

  logic            in_ready, out_valid, accept, w_eff;
  logic            signed_op, sa, sb, div0;
  logic [XLEN-1:0] mag_a, mag_b, quot_init, q_fin, r_fin, post_res;
  logic [CW-1:0]   cnt_init;
  int              n_bits, sh_amt;
`ifdef INTDIV_EARLY_TERM_EN
  logic [XLEN-1:0] norm;
  int              lz, z;
`endif

  logic [XLEN-1:0] rem_c  [0:BPC];
  logic [XLEN-1:0] quot_c [0:BPC];

  assign accept = bus.in_valid_i && !bus.flush_i && (state_q == IDLE);
  assign w_eff  = (XLEN == 64) && bus.w_i;

  // W forms use only the low word, extended according to signedness
  function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
    return r;
  endfunction

  // Chain of BPC restoring steps evaluated each ITER cycle
  assign rem_c[0]  = rem_q;
  assign quot_c[0] = quot_q;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    intdiv_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_c[g]),
      .quot_i (quot_c[g]),
      .dvs_i  (dvs_q),
      .rem_o  (rem_c[g+1]),
      .quot_o (quot_c[g+1])
    );
  end

  // Operand magnitudes, dividend pre-alignment and iteration count for PREP
  always_comb begin
    n_bits    = w_q ? 32 : XLEN;
    signed_op = ~op_q[0];
    sa        = signed_op & a_q[XLEN-1];
    sb        = signed_op & b_q[XLEN-1];
    mag_a     = sa ? -a_q : a_q;
    mag_b     = sb ? -b_q : b_q;
    div0      = (b_q == '0);
    sh_amt    = XLEN - n_bits;
`ifdef INTDIV_EARLY_TERM_EN
    norm = mag_a << sh_amt;
    lz   = XLEN;
    for (int i = 0; i < XLEN; i++) if (norm[i]) lz = XLEN - 1 - i;
    if (lz > n_bits) lz = n_bits;
    z        = (lz / BPC) * BPC;
    sh_amt   = sh_amt + z;
    cnt_init = CW'((n_bits - z) / BPC);
`else
    cnt_init = CW'(n_bits / BPC);
`endif
    quot_init = mag_a << sh_amt;
  end

  // Sign fix-up, quotient/remainder select and W-form sign extension for POST
  always_comb begin
    q_fin    = q_neg_q ? -quot_q : quot_q;
    r_fin    = r_neg_q ? -rem_q : rem_q;
    post_res = op_q[1] ? r_fin : q_fin;
    if (w_q) post_res = ext_w(post_res, 1'b1);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs; flush overrides everything outside IDLE
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = PREP;
      end
      PREP: state_d = (div0 || cnt_init == '0) ? POST : ITER;
      ITER: if (cnt_q == CW'(1)) state_d = POST;
      POST: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i && state_q != IDLE) state_d = IDLE;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.result_o    = result_q;

  // Datapath registers, updated according to the current phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= DIV;
      w_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q <= bus.op_i;
          w_q  <= w_eff;
          a_q  <= w_eff ? ext_w(bus.a_i, ~bus.op_i[0]) : bus.a_i;
          b_q  <= w_eff ? ext_w(bus.b_i, ~bus.op_i[0]) : bus.b_i;
        end
        PREP: begin
          // Divide by zero bypasses the iterations: quotient all ones, remainder = dividend
          q_neg_q <= div0 ? 1'b0 : (sa ^ sb);
          r_neg_q <= div0 ? 1'b0 : sa;
          dvs_q   <= mag_b;
          rem_q   <= div0 ? a_q : '0;
          quot_q  <= div0 ? '1 : quot_init;
          cnt_q   <= cnt_init;
        end
        ITER: begin
          rem_q  <= rem_c[BPC];
          quot_q <= quot_c[BPC];
          cnt_q  <= cnt_q - CW'(1);
        end
        POST: result_q <= post_res;
        default: ;
      endcase
    end
  end

endmodule
